// File: rtl/bf16_mul_arbiter.sv
// Round-robin arbiter sharing one external combinational bf16 multiplier among
// NUM_REQ requesters; operands and product are registered, one op in flight.
module bf16_mul_arbiter #(
  parameter  int NUM_REQ = 2,
  localparam int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [NUM_REQ-1:0]    req_valid_i,
  output logic [NUM_REQ-1:0]    req_ready_o,
  input  logic [16*NUM_REQ-1:0] req_a_i,
  input  logic [16*NUM_REQ-1:0] req_b_i,
  output logic [15:0]           mul_a_o,
  output logic [15:0]           mul_b_o,
  input  logic [15:0]           mul_c_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [ID_W-1:0]       rsp_id_o,
  output logic [15:0]           rsp_c_o,
  output logic                  busy_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0] id_q, id_d;
  logic [15:0]     mul_a_q, mul_a_d;
  logic [15:0]     mul_b_q, mul_b_d;
  logic [15:0]     rsp_c_q, rsp_c_d;
  logic [ID_W-1:0] rsp_id_q, rsp_id_d;
  logic            rsp_valid_q, rsp_valid_d;

  logic            accept_win_s;
  logic            grant_found_s;
  logic [ID_W-1:0] grant_idx_s;
  logic            fire_s;
  logic [ID_W:0]   cand_s;

  // Round-robin search starting one past the last winner; one extra bit keeps the wrap exact.
  always_comb begin
    grant_found_s = 1'b0;
    grant_idx_s   = '0;
    cand_s        = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand_s = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
      if (cand_s >= (ID_W+1)'(NUM_REQ)) begin
        cand_s = cand_s - (ID_W+1)'(NUM_REQ);
      end else begin
        cand_s = cand_s;
      end
      if (!grant_found_s && req_valid_i[cand_s[ID_W-1:0]]) begin
        grant_found_s = 1'b1;
        grant_idx_s   = cand_s[ID_W-1:0];
      end else begin
        grant_found_s = grant_found_s;
      end
    end
  end

  assign accept_win_s = (state_q == ST_IDLE) || ((state_q == ST_DONE) && rsp_ready_i);
  assign fire_s       = accept_win_s && grant_found_s;

  // One-hot ready to the winner, only while a new operation can be taken.
  always_comb begin
    req_ready_o = '0;
    if (fire_s) begin
      req_ready_o = NUM_REQ'(1) << grant_idx_s;
    end else begin
      req_ready_o = '0;
    end
  end

  // Next-state and datapath updates for the IDLE/BUSY/DONE sequence.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    id_d        = id_q;
    mul_a_d     = mul_a_q;
    mul_b_d     = mul_b_q;
    rsp_c_d     = rsp_c_q;
    rsp_id_d    = rsp_id_q;
    rsp_valid_d = rsp_valid_q;
    case (state_q)
      ST_IDLE: begin
        if (fire_s) begin
          state_d = ST_BUSY;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        state_d     = ST_DONE;
        rsp_c_d     = mul_c_i;
        rsp_id_d    = id_q;
        rsp_valid_d = 1'b1;
      end
      ST_DONE: begin
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          state_d     = fire_s ? ST_BUSY : ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        rsp_valid_d = 1'b0;
      end
    endcase
    // Operands persist after completion so the multiplier inputs stay quiet.
    if (fire_s) begin
      mul_a_d  = req_a_i[16*grant_idx_s +: 16];
      mul_b_d  = req_b_i[16*grant_idx_s +: 16];
      id_d     = grant_idx_s;
      rr_ptr_d = grant_idx_s;
    end else begin
      mul_a_d = mul_a_d;
    end
  end

  // State and datapath registers; pointer resets to the last index so requester 0 wins first.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= ID_W'(NUM_REQ - 1);
      id_q        <= '0;
      mul_a_q     <= 16'h0000;
      mul_b_q     <= 16'h0000;
      rsp_c_q     <= 16'h0000;
      rsp_id_q    <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      id_q        <= id_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      rsp_c_q     <= rsp_c_d;
      rsp_id_q    <= rsp_id_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign mul_a_o     = mul_a_q;
  assign mul_b_o     = mul_b_q;
  assign rsp_c_o     = rsp_c_q;
  assign rsp_id_o    = rsp_id_q;
  assign rsp_valid_o = rsp_valid_q;
  assign busy_o      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_bf16_mul_arbiter.sv
// Directed bench for bf16_mul_arbiter; the shared multiplier is a lookup table
// of hand-computed bf16 products for the operand pairs used below.
module tb_bf16_mul_arbiter;

  logic        clk_i;
  logic        rst_ni;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [15:0] mul_a;
  logic [15:0] mul_b;
  logic [15:0] mul_c;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [0:0]  rsp_id;
  logic [15:0] rsp_c;
  logic        busy;

  int checks = 0;
  int errors = 0;

  bf16_mul_arbiter #(.NUM_REQ(2)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_a_i     (req_a),
    .req_b_i     (req_b),
    .mul_a_o     (mul_a),
    .mul_b_o     (mul_b),
    .mul_c_i     (mul_c),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_id_o    (rsp_id),
    .rsp_c_o     (rsp_c),
    .busy_o      (busy)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  function automatic logic [15:0] bf16_ref(input logic [15:0] a, input logic [15:0] b);
    case ({a, b})
      32'h3F80_4000: bf16_ref = 16'h4000;
      32'h4040_3F00: bf16_ref = 16'h3FC0;
      32'hC000_4040: bf16_ref = 16'hC0C0;
      32'h7FC0_3F80: bf16_ref = 16'h7FC0;
      32'h7F80_0000: bf16_ref = 16'h7FC0;
      32'hFF80_4000: bf16_ref = 16'hFF80;
      32'h0000_4000: bf16_ref = 16'h0000;
      default:       bf16_ref = 16'h0BAD;
    endcase
  endfunction

  always_comb mul_c = bf16_ref(mul_a, mul_b);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk_i);
    #2;
  endtask

  // One isolated operation from requester idx, checked end to end.
  task automatic do_op(input int idx, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] exp_c);
    req_a[16*idx +: 16] = a;
    req_b[16*idx +: 16] = b;
    req_valid = 2'b00;
    req_valid[idx] = 1'b1;
    #1;
    chk("op_ready", {30'd0, req_ready}, 32'd1 << idx);
    tick;
    req_valid = 2'b00;
    tick;
    #1;
    chk("op_valid", {31'd0, rsp_valid}, 32'd1);
    chk("op_c", {16'd0, rsp_c}, {16'd0, exp_c});
    chk("op_id", {31'd0, rsp_id}, idx);
    tick;
  endtask

  initial begin
    rst_ni    = 1'b0;
    req_valid = 2'b00;
    req_a     = 32'h0;
    req_b     = 32'h0;
    rsp_ready = 1'b1;
    tick;
    tick;
    chk("rst_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_ready", {30'd0, req_ready}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_mul_a", {16'd0, mul_a}, 32'd0);
    chk("rst_rsp_c", {16'd0, rsp_c}, 32'd0);
    chk("rst_rsp_id", {31'd0, rsp_id}, 32'd0);
    rst_ni = 1'b1;
    tick;

    // Single request with latency check
    req_a[15:0] = 16'h3F80;
    req_b[15:0] = 16'h4000;
    req_valid   = 2'b01;
    #1;
    chk("t1_ready", {30'd0, req_ready}, 32'd1);
    chk("t1_busy_idle", {31'd0, busy}, 32'd0);
    tick;
    req_valid = 2'b00;
    #1;
    chk("t1_busy", {31'd0, busy}, 32'd1);
    chk("t1_mul_a", {16'd0, mul_a}, 32'h3F80);
    chk("t1_mul_b", {16'd0, mul_b}, 32'h4000);
    chk("t1_early_valid", {31'd0, rsp_valid}, 32'd0);
    tick;
    #1;
    chk("t1_valid", {31'd0, rsp_valid}, 32'd1);
    chk("t1_c", {16'd0, rsp_c}, 32'h4000);
    chk("t1_id", {31'd0, rsp_id}, 32'd0);
    tick;
    #1;
    chk("t1_drop", {31'd0, rsp_valid}, 32'd0);
    chk("t1_idle", {31'd0, busy}, 32'd0);
    chk("t1_hold_a", {16'd0, mul_a}, 32'h3F80);

    // Special values come straight from the multiplier
    do_op(0, 16'h7FC0, 16'h3F80, 16'h7FC0);
    do_op(1, 16'h7F80, 16'h0000, 16'h7FC0);
    do_op(0, 16'hFF80, 16'h4000, 16'hFF80);
    do_op(1, 16'h0000, 16'h4000, 16'h0000);

    // Reset mid-op after an r0 grant: r1 would win next without the reset
    do_op(0, 16'h3F80, 16'h4000, 16'h4000);
    req_valid = 2'b01;
    tick;
    req_valid = 2'b00;
    #1;
    chk("t5_busy_pre", {31'd0, busy}, 32'd1);
    rst_ni = 1'b0;
    #1;
    chk("t5_async_valid", {31'd0, rsp_valid}, 32'd0);
    chk("t5_async_busy", {31'd0, busy}, 32'd0);
    chk("t5_async_mul_a", {16'd0, mul_a}, 32'd0);
    tick;
    rst_ni = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick;
      chk("t5_no_rsp", {31'd0, rsp_valid}, 32'd0);
    end

    // Contention: both valid, grants alternate back to back
    req_a = {16'hC000, 16'h4040};
    req_b = {16'h4040, 16'h3F00};
    req_valid = 2'b11;
    #1;
    chk("t5_first_grant", {30'd0, req_ready}, 32'd1);
    tick;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t2_busy_ready", {30'd0, req_ready}, 32'd0);
      chk("t2_mul_a", {16'd0, mul_a}, (i % 2) ? 32'hC000 : 32'h4040);
      tick;
      #1;
      chk("t2_valid", {31'd0, rsp_valid}, 32'd1);
      chk("t2_id", {31'd0, rsp_id}, i % 2);
      chk("t2_c", {16'd0, rsp_c}, (i % 2) ? 32'hC0C0 : 32'h3FC0);
      chk("t2_next_grant", {30'd0, req_ready}, (i % 2) ? 32'd1 : 32'd2);
      tick;
    end

    // Backpressure in DONE with r1 waiting
    req_valid = 2'b10;
    tick;
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t3_valid", {31'd0, rsp_valid}, 32'd1);
      chk("t3_c", {16'd0, rsp_c}, 32'h3FC0);
      chk("t3_id", {31'd0, rsp_id}, 32'd0);
      chk("t3_ready", {30'd0, req_ready}, 32'd0);
      chk("t3_busy", {31'd0, busy}, 32'd1);
      tick;
    end
    rsp_ready = 1'b1;
    #1;
    chk("t3_release_grant", {30'd0, req_ready}, 32'd2);
    tick;
    req_valid = 2'b00;
    #1;
    chk("t3_valid_drop", {31'd0, rsp_valid}, 32'd0);
    chk("t3_mul_a", {16'd0, mul_a}, 32'hC000);
    tick;
    #1;
    chk("t3_c1", {16'd0, rsp_c}, 32'hC0C0);
    chk("t3_id1", {31'd0, rsp_id}, 32'd1);
    tick;

    // Idle cycles after an r1 grant do not rotate priority
    for (int i = 0; i < 10; i++) begin
      tick;
      chk("t6_idle", {31'd0, busy}, 32'd0);
    end
    req_valid = 2'b11;
    #1;
    chk("t6_grant_r0", {30'd0, req_ready}, 32'd1);
    tick;
    req_valid = 2'b00;
    tick;
    #1;
    chk("t6_id", {31'd0, rsp_id}, 32'd0);
    chk("t6_c", {16'd0, rsp_c}, 32'h3FC0);
    tick;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
